// File: rtl/riscv_pkg.sv
// Shared width and state/owner types for the unified memory-port arbiter.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_t;
  typedef enum logic       {OWN_IF, OWN_D}               arb_owner_t;
endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick between fetch and data requesters; on a tie the
// requester that did not own the previous transaction wins.
module mem_arb_rr2
  import riscv_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_d_i,
  input  arb_owner_t last_owner_i,
  output logic [1:0] gnt_o,   // bit 0 = IF, bit 1 = D
  output arb_owner_t owner_o
);
  always_comb begin
    gnt_o   = 2'b00;
    owner_o = last_owner_i;
    if (req_if_i && req_d_i) begin
      owner_o = (last_owner_i == OWN_IF) ? OWN_D : OWN_IF;
      gnt_o   = (owner_o == OWN_D) ? 2'b10 : 2'b01;
    end else if (req_d_i) begin
      owner_o = OWN_D;
      gnt_o   = 2'b10;
    end else if (req_if_i) begin
      owner_o = OWN_IF;
      gnt_o   = 2'b01;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and load/store,
// one outstanding transaction at a time, with a wait-timeout error response.
module mem_port_arbiter #(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  output logic            if_err_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [3:0]      d_be_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);
  import riscv_pkg::*;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t      state_q;
  arb_owner_t      owner_q, last_q, gnt_owner;
  logic [1:0]      gnt_vec;
  logic [XLEN-1:0] addr_q, wdata_q, addr_d, wdata_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [CNT_W-1:0] cnt_q;
  logic            if_rvalid_q, if_err_q, d_rvalid_q, d_err_q;
  logic [XLEN-1:0] if_rdata_q, d_rdata_q;
  logic            gnt_ok, timeout_hit;

  mem_arb_rr2 u_rr (
    .req_if_i     (if_req_i),
    .req_d_i      (d_req_i),
    .last_owner_i (last_q),
    .gnt_o        (gnt_vec),
    .owner_o      (gnt_owner)
  );

  // Grants are only offered while idle and never while reset is asserted.
  assign gnt_ok   = (state_q == ARB_IDLE) && !rst_i;
  assign if_gnt_o = gnt_ok && gnt_vec[0];
  assign d_gnt_o  = gnt_ok && gnt_vec[1];

  always_comb begin
    if (gnt_owner == OWN_D) begin
      addr_d  = d_addr_i & ~XLEN'(3);
      we_d    = d_we_i;
      be_d    = d_be_i;
      wdata_d = d_wdata_i;
    end else begin
      addr_d  = if_addr_i & ~XLEN'(3);
      we_d    = 1'b0;
      be_d    = 4'hF;
      wdata_d = '0;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (|gnt_vec) begin
            owner_q <= gnt_owner;
            last_q  <= gnt_owner;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            state_q <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_gnt_i) begin
            cnt_q   <= '0;
            state_q <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A real response beats a timeout landing on the same cycle.
          if (mem_rvalid_i || timeout_hit) begin
            state_q <= ARB_IDLE;
            if (owner_q == OWN_D) begin
              d_rvalid_q <= 1'b1;
              d_err_q    <= !mem_rvalid_i;
              d_rdata_q  <= mem_rvalid_i ? mem_rdata_i : '0;
            end else begin
              if_rvalid_q <= 1'b1;
              if_err_q    <= !mem_rvalid_i;
              if_rdata_q  <= mem_rvalid_i ? mem_rdata_i : '0;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_req_o   = (state_q == ARB_REQ);
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign if_rvalid_o = if_rvalid_q;
  assign if_err_o    = if_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model
// compared on every falling edge, plus hand-computed checkpoints.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, d_req_i, d_we_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [3:0]  d_be_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o, d_gnt_o, d_rvalid_o, d_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_port_arbiter #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  // Reference model: one transaction record (owner 0 = IF, 1 = D) that is
  // pending, accepted by memory, then answered or timed out.
  bit          m_busy, m_acc;
  int          m_own, m_last, m_wait;
  logic [31:0] m_addr, m_wdata, m_ifd, m_dd;
  logic        m_we, m_ifv, m_ife, m_dv, m_de;
  logic [3:0]  m_be;

  always @(negedge clk_i) begin : model
    int pick;
    if (rst_i) begin
      m_busy = 0; m_acc = 0; m_own = 0; m_last = 0; m_wait = 0;
      m_addr = 0; m_wdata = 0; m_we = 0; m_be = 0;
      m_ifv = 0; m_ife = 0; m_dv = 0; m_de = 0; m_ifd = 0; m_dd = 0;
    end
    pick = -1;
    if (!rst_i && !m_busy) begin
      if (if_req_i && d_req_i) pick = 1 - m_last;
      else if (d_req_i)        pick = 1;
      else if (if_req_i)       pick = 0;
    end
    chk("m_if_gnt", if_gnt_o, pick == 0);
    chk("m_d_gnt", d_gnt_o, pick == 1);
    chk("m_mem_req", mem_req_o, m_busy && !m_acc);
    if (m_busy && !m_acc) begin
      chk("m_mem_addr", mem_addr_o, m_addr);
      chk("m_mem_we", mem_we_o, m_we);
      chk("m_mem_be", mem_be_o, m_be);
      chk("m_mem_wdata", mem_wdata_o, m_wdata);
    end
    chk("m_if_rvalid", if_rvalid_o, m_ifv);
    chk("m_if_err", if_err_o, m_ife);
    chk("m_if_rdata", if_rdata_o, m_ifd);
    chk("m_d_rvalid", d_rvalid_o, m_dv);
    chk("m_d_err", d_err_o, m_de);
    chk("m_d_rdata", d_rdata_o, m_dd);
    if (!rst_i) begin
      m_ifv = 0; m_ife = 0; m_dv = 0; m_de = 0;
      if (pick >= 0) begin
        m_busy = 1; m_acc = 0; m_own = pick; m_last = pick;
        if (pick == 1) begin
          m_addr = d_addr_i & 32'hFFFF_FFFC; m_we = d_we_i; m_be = d_be_i; m_wdata = d_wdata_i;
        end else begin
          m_addr = if_addr_i & 32'hFFFF_FFFC; m_we = 0; m_be = 4'hF; m_wdata = 0;
        end
      end else if (m_busy && !m_acc) begin
        if (mem_gnt_i) begin m_acc = 1; m_wait = 0; end
      end else if (m_busy) begin
        if (mem_rvalid_i || m_wait == TO - 1) begin
          m_busy = 0;
          if (m_own == 1) begin
            m_dv = 1; m_de = !mem_rvalid_i; m_dd = mem_rvalid_i ? mem_rdata_i : 32'h0;
          end else begin
            m_ifv = 1; m_ife = !mem_rvalid_i; m_ifd = mem_rvalid_i ? mem_rdata_i : 32'h0;
          end
        end else m_wait++;
      end
    end
  end

  int          grants, coinc;
  logic [3:0]  gseq;

  initial begin
    rst_i = 1; if_req_i = 1; d_req_i = 1; if_addr_i = 0; d_we_i = 0; d_be_i = 0;
    d_addr_i = 0; d_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    mid();
    chk("rst_if_gnt", if_gnt_o, 0);
    chk("rst_d_gnt", d_gnt_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    nxt(); rst_i = 0; if_req_i = 0; d_req_i = 0;
    nxt();

    // single IF fetch
    nxt(); if_req_i = 1; if_addr_i = 32'h0000_0106;
    mid(); chk("if_gnt_c0", if_gnt_o, 1);
    nxt(); if_req_i = 0; mem_gnt_i = 1;
    mid(); chk("if_mem_addr_c1", mem_addr_o, 32'h0000_0104);
           chk("if_mem_be_c1", mem_be_o, 4'hF);
           chk("if_mem_we_c1", mem_we_o, 0);
    nxt(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0050_0093;
    nxt(); mem_rvalid_i = 0; mem_rdata_i = 0;
    mid(); chk("if_rvalid_c3", if_rvalid_o, 1);
           chk("if_rdata_c3", if_rdata_o, 32'h0050_0093);
    nxt();
    mid(); chk("if_rdata_hold", if_rdata_o, 32'h0050_0093);

    // store with two memory wait cycles; inputs scrambled after grant
    nxt(); d_req_i = 1; d_we_i = 1; d_be_i = 4'h3; d_addr_i = 32'h200; d_wdata_i = 32'h0000_BEEF;
    mid(); chk("st_gnt", d_gnt_o, 1);
    nxt(); d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 32'hFFFF_FFFF; d_wdata_i = 0;
    mid(); chk("st_mem_wdata_c1", mem_wdata_o, 32'h0000_BEEF);
    nxt();
    mid(); chk("st_mem_req_c2", mem_req_o, 1);
    nxt(); mem_gnt_i = 1;
    mid(); chk("st_mem_be_c3", mem_be_o, 4'h3);
    nxt(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
    mid(); chk("st_mem_req_drop", mem_req_o, 0);
    nxt(); mem_rvalid_i = 0;
    mid(); chk("st_rvalid", d_rvalid_o, 1); chk("st_err", d_err_o, 0);
    nxt();
    mid(); chk("st_rvalid_once", d_rvalid_o, 0);

    // timeout: response five cycles after the mem_gnt cycle
    nxt(); d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 32'h300;
    nxt(); d_req_i = 0; mem_gnt_i = 1;
    nxt(); mem_gnt_i = 0;
    mid(); chk("to_quiet_c2", d_rvalid_o, 0);
    for (int c = 3; c <= 5; c++) begin nxt(); mid(); chk("to_quiet", d_rvalid_o, 0); end
    nxt();
    mid(); chk("to_rvalid", d_rvalid_o, 1); chk("to_err", d_err_o, 1); chk("to_rdata", d_rdata_o, 0);

    // rvalid on the same cycle the timeout would fire
    nxt(); d_req_i = 1; d_addr_i = 32'h304;
    nxt(); d_req_i = 0; mem_gnt_i = 1;
    nxt(); mem_gnt_i = 0;
    nxt(); nxt();
    nxt(); mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    mid(); chk("co_no_early", d_rvalid_o, 0);
    nxt(); mem_rvalid_i = 0;
    mid(); chk("co_rvalid", d_rvalid_o, 1); chk("co_err", d_err_o, 0);
           chk("co_rdata", d_rdata_o, 32'hCAFE_F00D);

    // reset while waiting; late rvalid must be ignored, D wins the next tie
    nxt(); d_req_i = 1; d_addr_i = 32'h400;
    nxt(); d_req_i = 0; mem_gnt_i = 1;
    nxt(); mem_gnt_i = 0; rst_i = 1;
    mid(); chk("rm_mem_req", mem_req_o, 0);
    nxt(); rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_0000;
    mid(); chk("rm_no_rvalid", d_rvalid_o, 0);
    nxt(); mem_rvalid_i = 0;
    mid(); chk("rm_no_rvalid2", d_rvalid_o, 0);
    nxt(); if_req_i = 1; d_req_i = 1; d_addr_i = 32'h500; if_addr_i = 32'h80;
    mid(); chk("rm_d_wins", d_gnt_o, 1); chk("rm_if_waits", if_gnt_o, 0);
    nxt(); if_req_i = 0; d_req_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1;
    repeat (3) nxt();
    mem_gnt_i = 0; mem_rvalid_i = 0;

    // both requesters held from reset release
    rst_i = 1; if_req_i = 1; d_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    mem_rdata_i = 32'hA5A5_0000;
    nxt(); rst_i = 0;
    grants = 0; gseq = '0; coinc = 0;
    for (int c = 0; c < 30 && grants < 4; c++) begin
      mid();
      if (if_rvalid_o && d_rvalid_o) coinc++;
      if (if_gnt_o || d_gnt_o) begin gseq[grants] = d_gnt_o; grants++; end
      if (grants < 4) begin nxt(); mem_rdata_i = mem_rdata_i + 1; end
    end
    nxt(); if_req_i = 0; d_req_i = 0;
    for (int c = 0; c < 4; c++) begin mid(); if (if_rvalid_o && d_rvalid_o) coinc++; nxt(); end
    mem_gnt_i = 0; mem_rvalid_i = 0;
    chk("tie_grant_count", grants, 4);
    chk("tie_order", gseq, 4'b0101);
    chk("tie_no_coincident", coinc, 0);

    repeat (3) nxt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between instruction fetch (IF) and load/store (D) requesters.
- Lets the RV32I core move from separate IMEM/DMEM to a single memory with multi-cycle access.
- Handles one outstanding transaction at a time, with round-robin arbitration on ties.
- A wait-timeout returns an error response so a stalled memory cannot hang the core.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT, 64, maximum cycles in WAIT before an error response; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- if_req_i  in  1  fetch request; held with address until if_gnt_o
- if_addr_i  in  XLEN  fetch address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  XLEN  fetch read data
- if_err_o  out  1  fetch response is a timeout error
- d_req_i  in  1  data request; held with all fields until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_be_i  in  4  byte enables
- d_addr_i  in  XLEN  data address
- d_wdata_i  in  XLEN  store data
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  data response valid; pulses for stores too
- d_rdata_o  out  XLEN  load data
- d_err_o  out  1  data response is a timeout error
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  XLEN  word-aligned memory address
- mem_wdata_o  out  XLEN  memory write data
- mem_gnt_i  in  1  memory accepted the request this cycle
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  XLEN  memory read data

Behaviour:
- States: IDLE, REQ, WAIT.
- Reset: state = IDLE, last_owner = IF, timeout counter = 0.
- Reset values: all registered outputs are 0. if_gnt_o/d_gnt_o are combinational and also read 0 during reset.
- IDLE:
  - If exactly one requester has req=1, it is granted.
  - If both have req=1, the one that is not last_owner is granted, so D wins the first tie after reset.
  - Granted requester's gnt_o = 1 in that same cycle.
  - Captured into internal registers on that edge: owner, addr & ~3, we (IF forces 0), be (IF forces 4'hF), wdata (IF forces 0).
  - Next state is REQ; last_owner is updated to the granted requester.
  - With no request, stay in IDLE.
- REQ:
  - mem_req_o = 1; mem_we_o/be_o/addr_o/wdata_o driven from the captured registers and held stable.
  - On mem_gnt_i = 1, go to WAIT and clear the counter; otherwise stay in REQ (no timeout in REQ).
  - No gnt_o is issued in REQ.
- WAIT:
  - mem_req_o = 0; the counter increments each cycle.
  - On mem_rvalid_i = 1: next cycle the owner's rvalid_o = 1, rdata_o = mem_rdata_i (registered), err_o = 0; state goes to IDLE.
  - On timeout (TIMEOUT ≠ 0 and counter == TIMEOUT-1 with no rvalid): next cycle the owner's rvalid_o = 1, err_o = 1, rdata_o = 0; state goes to IDLE.
  - If rvalid and timeout coincide, rvalid wins and err_o = 0.
- Response timing:
  - rvalid_o/err_o are single-cycle pulses.
  - rdata_o holds its last value between pulses.
  - The non-owner's rvalid_o stays 0.
- New-grant timing: a new grant can occur in the same cycle as the previous response pulse, since state is already IDLE.
- Minimum transaction: grant cycle 0, mem_req cycle 1 (with mem_gnt_i), mem_rvalid_i cycle 2, rvalid_o cycle 3.
- mem_rvalid_i outside WAIT is ignored.
- Requester dropping req before gnt is legal; nothing is captured.
- Reset mid-transaction: return to IDLE immediately; the pending response is dropped and no rvalid_o is issued.

Decomposition:
- riscv_pkg holds:
  - XLEN
  - typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_t
  - typedef enum logic {OWN_IF, OWN_D} arb_owner_t
- One combinational sub-module, mem_arb_rr2:
  - Inputs: req_if, req_d, last_owner.
  - Outputs: one-hot grant and the granted owner.

Test Plan:
- Single IF fetch:
  - Stimulus: if_req_i = 1, if_addr_i = 0x00000106; memory grants immediately and returns 0x00500093 one cycle later.
  - Required: if_gnt_o at cycle 0; mem_addr_o = 0x00000104, mem_be_o = 0xF, mem_we_o = 0 at cycle 1; if_rvalid_o = 1, if_rdata_o = 0x00500093 at cycle 3.
- Store:
  - Stimulus: d_we_i = 1, d_be_i = 0x3, d_addr_i = 0x200, d_wdata_i = 0x0000BEEF; memory grants after 2 wait cycles.
  - Required: mem_req_o held for 3 cycles with stable fields; d_rvalid_o pulses once; d_err_o = 0.
- Simultaneous requests after reset:
  - Stimulus: both requesters hold req = 1 from reset release.
  - Required: grants alternate D, IF, D, IF across 4 transactions; no if_rvalid_o ever coincides with d_rvalid_o.
- Timeout:
  - Stimulus: TIMEOUT = 4; memory grants but never asserts rvalid.
  - Required: d_rvalid_o = 1, d_err_o = 1, d_rdata_o = 0 exactly 5 cycles after the mem_gnt_i cycle; state returns to IDLE.
- Coincident rvalid and timeout:
  - Stimulus: mem_rvalid_i arrives on the cycle the counter reaches TIMEOUT-1.
  - Required: err_o = 0 and data is delivered.
- Reset mid-transaction:
  - Stimulus: rst_i asserted while in WAIT, then mem_rvalid_i arrives after reset.
  - Required: no rvalid_o; mem_req_o = 0; the next request is granted normally with D priority.
